// File: rtl/fp_expand.sv
// Compact FP word (sign, exponent, significand) to two's-complement linear value.
// Iterative shifter: one left shift per clock, valid/ready on both sides.
module fp_expand #(
  parameter int E_W = 3,
  parameter int M_W = 4,
  parameter int D_W = 12
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           sign,
  input  logic [E_W-1:0] exp,
  input  logic [M_W-1:0] significand,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [D_W-1:0] d_out,
  output logic           busy
);

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    SIGN,
    DONE
  } state_e;

  state_e         state_q, state_d;
  logic [D_W-1:0] mag_q, mag_d;
  logic [E_W-1:0] cnt_q, cnt_d;
  logic           sgn_q, sgn_d;
  logic [D_W-1:0] dout_q, dout_d;
  logic           in_ready_q, in_ready_d;
  logic           out_valid_q, out_valid_d;
  logic           busy_q, busy_d;

  always_comb begin
    state_d = state_q;
    mag_d   = mag_q;
    cnt_d   = cnt_q;
    sgn_d   = sgn_q;
    dout_d  = dout_q;
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          mag_d   = D_W'(significand);
          cnt_d   = exp;
          sgn_d   = sign;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          mag_d = mag_q << 1;
          cnt_d = cnt_q - E_W'(1);
        end else begin
          state_d = SIGN;
        end
      end
      SIGN: begin
        dout_d  = sgn_q ? (~mag_q + D_W'(1)) : mag_q;
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Handshake flags follow the next state so they are registered.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      mag_q       <= '0;
      cnt_q       <= '0;
      sgn_q       <= 1'b0;
      dout_q      <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mag_q       <= mag_d;
      cnt_q       <= cnt_d;
      sgn_q       <= sgn_d;
      dout_q      <= dout_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign d_out     = dout_q;

endmodule

// File: tb/tb_fp_expand.sv
// Randomized and directed bench for fp_expand against an arithmetic model,
// including a full linear -> FP -> linear loopback sweep.
module tb_fp_expand;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic        sign;
  logic [2:0]  exp;
  logic [3:0]  significand;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] d_out;
  logic        busy;

  int n_pass = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  fp_expand dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .sign(sign), .exp(exp), .significand(significand),
    .out_valid(out_valid), .out_ready(out_ready),
    .d_out(d_out), .busy(busy)
  );

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] want);
    n_total++;
    if (got === want) n_pass++;
    else $display("FAIL %s got=%0h want=%0h", tag, got, want);
  endtask

  // Decode one word; stall = cycles out_ready stays low in DONE,
  // poke = raise in_valid with junk data while the word is in flight.
  task automatic run_word(input logic s, input logic [2:0] e,
                          input logic [3:0] f, input int stall,
                          input bit poke, output int dv);
    int want, lat;
    logic [11:0] want12;
    want   = (s ? -1 : 1) * int'(f) * (1 << e);
    want12 = want[11:0];
    out_ready   = (stall == 0);
    sign        = s;
    exp         = e;
    significand = f;
    in_valid    = 1'b1;
    @(posedge clk); #1;
    in_valid    = 1'b0;
    sign        = ~s;
    exp         = ~e;
    significand = ~f;
    lat = 0;
    @(negedge clk);
    check("busy_run", busy, 1);
    while (!out_valid && lat < 20) begin
      @(posedge clk); lat++; #1;
      in_valid = poke && (lat == 1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    check("latency", lat, e + 2);
    check("d_out", d_out, want12);
    check("in_ready_done", in_ready, 0);
    for (int i = 0; i < stall; i++) begin
      @(negedge clk);
      check("stall_valid", out_valid, 1);
      check("stall_d_out", d_out, want12);
      check("stall_in_ready", in_ready, 0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    check("post_valid", out_valid, 0);
    check("post_in_ready", in_ready, 1);
    check("post_busy", busy, 0);
    check("post_d_out", d_out, want12);
    out_ready = 1'b0;
    dv = int'($signed(d_out));
  endtask

  initial begin
    int dv, x, m, err;
    logic s;
    logic [2:0] e;
    logic [3:0] f;
    bit ov_seen;

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b0;
    sign = 1'b0;
    exp = '0;
    significand = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_d_out", d_out, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_in_ready", in_ready, 1);
    check("rst_busy", busy, 0);

    run_word(1'b0, 3'd0, 4'd1, 0, 1'b0, dv);
    run_word(1'b0, 3'd7, 4'd15, 0, 1'b0, dv);
    check("max_pos", dv, 1920);
    run_word(1'b1, 3'd7, 4'd15, 0, 1'b0, dv);
    check("max_neg", dv, -1920);
    run_word(1'b1, 3'd3, 4'd5, 5, 1'b0, dv);
    check("neg40", dv, -40);
    run_word(1'b1, 3'd4, 4'd0, 0, 1'b1, dv);
    check("neg_zero", dv, 0);

    // Reset while an E=6 word is shifting.
    sign = 1'b0; exp = 3'd6; significand = 4'd9; in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_d_out", d_out, 0);
    ov_seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (out_valid) ov_seen = 1'b1;
    end
    check("mid_rst_no_valid", ov_seen, 0);
    run_word(1'b0, 3'd6, 4'd9, 0, 1'b0, dv);
    check("after_rst", dv, 576);

    for (int k = 0; k < 300; k++) begin
      s = 1'($urandom);
      e = 3'($urandom);
      f = 4'($urandom);
      run_word(s, e, f, $urandom_range(0, 3), 1'($urandom), dv);
    end

    // Loopback: behavioural encoder then the DUT.
    for (int xi = -2048; xi < 2048; xi++) begin
      x = xi;
      s = (x < 0);
      m = s ? -x : x;
      e = 0;
      while ((m >> e) > 15 && e < 7) e++;
      f = ((m >> e) > 15) ? 4'd15 : 4'(m >> e);
      run_word(s, e, f, 0, 1'b0, dv);
      err = dv - x;
      if (err < 0) err = -err;
      if (x == -2048) check("lb_sat", dv, -1920);
      else check("lb_err", err <= ((1 << e) - 1), 1);
      check("lb_sign", (dv < 0) == (x < 0), 1);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
